asi_rmem: RTL

- Read-side memory backend on the user clock, directly downstream of the AXI slave read interface.
- Consumes its per-beat read strobes (m_re, m_raddr, m_rsize) and drives a single-port synchronous SRAM.
- Returns m_rdata/m_rvalid/m_rslverr exactly SLV_WS cycles after each strobe, matching the interface's delayed RID/RRESP/RLAST sideband.
- Performs range checking, narrow/unaligned byte-lane masking and saturating read/error counting.

---
 rtl/asi_pkg.sv | 27 ++
 rtl/asi_pipe_dly.sv | 38 +++
 rtl/asi_rmem.sv | 135 +++++++++++++
 3 files changed

// File: rtl/asi_pkg.sv
// Shared AXI slave widths and helpers for the read and write memory backends.
package asi_pkg;

    localparam int AXI_AW = 32;
    localparam int AXI_DW = 32;
    localparam int AXI_SW = 3;
    localparam int AXI_BW = AXI_DW / 8;
    localparam int AXI_LG = $clog2(AXI_BW);

    // Active lanes run from the beat address up to the end of its size container.
    function automatic logic [AXI_BW-1:0] lane_mask(input logic [AXI_LG-1:0] addr_lo,
                                                    input logic [AXI_SW-1:0] size);
        int lo;
        int sz;
        int hi;
        logic [AXI_BW-1:0] m;
        lo = int'(addr_lo);
        sz = 1 << size;
        hi = (lo & ~(sz - 1)) + sz;
        m  = '0;
        for (int i = 0; i < AXI_BW; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/asi_pipe_dly.sv
// Fixed-depth valid/data delay line; only the valid bits are reset.
module asi_pipe_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        dat_q[0] <= dat_i;
        for (int i = 1; i < DEPTH; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/asi_rmem.sv
// Read-side SRAM backend: range/size checking, lane masking and a fixed-latency return path.
module asi_rmem
    import asi_pkg::*;
#(
    parameter int                SLV_WS    = 2,
    parameter int                MEM_LAT   = 1,
    parameter logic [AXI_AW-1:0] MEM_BASE  = '0,
    parameter int                MEM_WORDS = 1024,
    parameter int                CNT_W     = 16
) (
    input  logic                         usr_clk,
    input  logic                         usr_reset,
    input  logic                         m_re,
    input  logic [AXI_AW-1:0]            m_raddr,
    input  logic [AXI_SW-1:0]            m_rsize,
    output logic [AXI_DW-1:0]            m_rdata,
    output logic                         m_rvalid,
    output logic                         m_rslverr,
    output logic                         mem_ce,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [AXI_DW-1:0]            mem_rdata,
    input  logic                         cnt_clr,
    output logic [CNT_W-1:0]             rd_cnt,
    output logic [CNT_W-1:0]             err_cnt
);

    localparam int              MAW       = $clog2(MEM_WORDS);
    localparam int              SW        = 1 + AXI_BW;
    localparam logic [AXI_AW:0] WIN_BYTES = (AXI_AW + 1)'(MEM_WORDS * AXI_BW);

    if (MEM_LAT < 1 || MEM_LAT > SLV_WS || SLV_WS > 8) begin : g_badParams
        $error("asi_rmem: need 1 <= MEM_LAT <= SLV_WS <= 8");
    end

    logic [AXI_AW-1:0] off;
    logic              rangeErr;
    logic              sizeErr;
    logic              beatErr;
    logic [AXI_BW-1:0] laneMask;

    assign off      = m_raddr - MEM_BASE;
    assign rangeErr = (m_raddr < MEM_BASE) || ({1'b0, off} >= WIN_BYTES);
    assign sizeErr  = m_rsize > AXI_SW'(AXI_LG);
    assign beatErr  = rangeErr | sizeErr;
    assign laneMask = lane_mask(m_raddr[AXI_LG-1:0], m_rsize);
    assign mem_ce   = m_re & ~beatErr & ~usr_reset;
    assign mem_addr = MAW'(off >> AXI_LG);

    logic          sideVld;
    logic [SW-1:0] sideDat;
    logic          outVld;
    logic [SW-1:0] outSide;
    logic [AXI_DW-1:0] outData;

    asi_pipe_dly #(.DEPTH(MEM_LAT), .W(SW)) u_sideDly (
        .clk_i   (usr_clk),
        .reset_i (usr_reset),
        .vld_i   (m_re & ~usr_reset),
        .dat_i   ({beatErr, laneMask}),
        .vld_o   (sideVld),
        .dat_o   (sideDat)
    );

    // SRAM data joins the sideband at stage MEM_LAT and rides with it to the output.
    if (SLV_WS > MEM_LAT) begin : g_dataDly
        asi_pipe_dly #(.DEPTH(SLV_WS - MEM_LAT), .W(SW + AXI_DW)) u_dataDly (
            .clk_i   (usr_clk),
            .reset_i (usr_reset),
            .vld_i   (sideVld),
            .dat_i   ({sideDat, mem_rdata}),
            .vld_o   (outVld),
            .dat_o   ({outSide, outData})
        );
    end else begin : g_dataDirect
        assign outVld  = sideVld;
        assign outSide = sideDat;
        assign outData = mem_rdata;
    end

    logic              outValid;
    logic [AXI_DW-1:0] byteMask;
    logic [AXI_DW-1:0] maskedData;
    logic [AXI_DW-1:0] rdata_q;

    always_comb begin
        byteMask = '0;
        for (int i = 0; i < AXI_BW; i++) begin
            byteMask[8*i +: 8] = {8{outSide[i]}};
        end
    end

    assign outValid   = outVld & ~usr_reset;
    assign maskedData = outSide[AXI_BW] ? '0 : (outData & byteMask);
    assign m_rvalid   = outValid;
    assign m_rslverr  = outValid & outSide[AXI_BW];
    assign m_rdata    = outValid ? maskedData : rdata_q;

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            rdata_q <= '0;
        end else if (outValid) begin
            rdata_q <= maskedData;
        end
    end

    logic [CNT_W-1:0] rdCnt_q, rdCnt_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    // Saturating statistics; a clear overrides any increment in the same cycle.
    always_comb begin
        rdCnt_d  = rdCnt_q;
        errCnt_d = errCnt_q;
        if (cnt_clr) begin
            rdCnt_d  = '0;
            errCnt_d = '0;
        end else if (m_rvalid) begin
            if (rdCnt_q != '1) rdCnt_d = rdCnt_q + CNT_W'(1);
            if (m_rslverr && errCnt_q != '1) errCnt_d = errCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            rdCnt_q  <= '0;
            errCnt_q <= '0;
        end else begin
            rdCnt_q  <= rdCnt_d;
            errCnt_q <= errCnt_d;
        end
    end

    assign rd_cnt  = rdCnt_q;
    assign err_cnt = errCnt_q;

endmodule
